// File: rtl/tx_fsm.sv
// Request-side dispatcher: decodes a host request to a switch instance,
// waits out that instance's busy, then issues a one-cycle tagged pulse.
module tx_fsm #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int A_WIDTH     = 8,
    parameter int SW_ADDR_LSB = 5,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_wr,
    input  logic [A_WIDTH-1:0]     req_addr,
    input  logic [W_WIDTH-1:0]     req_wdata,
    input  logic [NUM_SW_INST-1:0] sw_busy,
    output logic [NUM_SW_INST-1:0] sw_req,
    output logic [7:0]             sw_op_id,
    output logic                   sw_wr,
    output logic [A_WIDTH-1:0]     sw_addr,
    output logic [W_WIDTH-1:0]     sw_wdata,
    output logic                   err_valid,
    output logic [1:0]             err_code
);

    localparam int IW = A_WIDTH - SW_ADDR_LSB;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_ERR
    } state_t;

    state_t state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0] op_q;
    logic wr_q;
    logic [A_WIDTH-1:0] addr_q;
    logic [W_WIDTH-1:0] wdata_q;
    logic [IW-1:0] idx;
    logic [NUM_SW_INST-1:0] hit;
    logic busy_t;
    logic dec_err;
    logic [1:0] code_d;

    assign idx = addr_q[A_WIDTH-1:SW_ADDR_LSB];
    assign req_ready = (state_q == S_IDLE);

    // Decode target, select its busy bit, and compute next state
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        code_d  = 2'd0;
        busy_t  = 1'b0;
        hit     = '0;
        dec_err = (int'(idx) >= NUM_SW_INST);
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (int'(idx) == i) begin
                busy_t = sw_busy[i];
                hit[i] = 1'b1;
            end
        end
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_CHECK;
                    tcnt_d  = '0;
                end
            end
            S_CHECK: begin
                if (dec_err) begin
                    state_d = S_ERR;
                    code_d  = 2'd1;
                end else if (!busy_t) begin
                    state_d = S_ISSUE;
                end else if (tcnt_q == T_LAST) begin
                    state_d = S_ERR;
                    code_d  = 2'd2;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_ISSUE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and busy-wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Capture the host request on acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == S_IDLE && req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Registered issue/error outputs; op_id advances only on a real issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= 8'd1;
            sw_req    <= '0;
            sw_op_id  <= 8'd0;
            sw_wr     <= 1'b0;
            sw_addr   <= '0;
            sw_wdata  <= '0;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            sw_req    <= '0;
            sw_op_id  <= 8'd0;
            sw_wr     <= 1'b0;
            sw_addr   <= '0;
            sw_wdata  <= '0;
            err_valid <= 1'b0;
            err_code  <= 2'd0;
            if (state_d == S_ISSUE) begin
                sw_req   <= hit;
                sw_op_id <= op_q;
                sw_wr    <= wr_q;
                sw_addr  <= addr_q;
                sw_wdata <= wdata_q;
                op_q     <= (op_q == 8'hFF) ? 8'd1 : op_q + 8'd1;
            end
            if (state_d == S_ERR) begin
                err_valid <= 1'b1;
                err_code  <= code_d;
            end
        end
    end

endmodule
